// File: rtl/cnt_sequencer.sv
// cnt_sequencer: steps a hardware counter through a programmable threshold table.
// Define CNT_SEQ_LOOP_EN to let loop_i restart the table after the last stage.
module cnt_sequencer #(
  parameter int NUM_STAGES = 4,
  parameter int CW         = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            start_i,
  input  logic                            abort_i,
  input  logic                            loop_i,
  input  logic                            cfg_we_i,
  input  logic [$clog2(NUM_STAGES)-1:0]   cfg_idx_i,
  input  logic [CW-1:0]                   cfg_thr_i,
  input  logic [$clog2(NUM_STAGES):0]     cfg_num_i,
  input  logic                            cnt_tc_i,
  output logic                            cnt_en_o,
  output logic                            cnt_clr_o,
  output logic [CW-1:0]                   cnt_thr_o,
  output logic                            busy_o,
  output logic [$clog2(NUM_STAGES)-1:0]   stage_o,
  output logic                            stage_done_o,
  output logic                            seq_done_o
);

  localparam int SW = $clog2(NUM_STAGES);
  localparam int NW = SW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   table_q [NUM_STAGES];
  logic [NW-1:0]   num_q, num_d, num_clamped;
  logic [SW-1:0]   stage_d, stage_inc;
  logic [CW-1:0]   thr_d;
  logic            stage_done_d, seq_done_d;
  logic            last_stage;
  logic            loop_en;

`ifdef CNT_SEQ_LOOP_EN
  assign loop_en = loop_i;
`else
  logic unused_loop;
  assign unused_loop = loop_i;
  assign loop_en     = 1'b0;
`endif

  // A zero stage count still runs one stage; oversized counts run the whole table.
  always_comb begin
    if (cfg_num_i == '0) begin
      num_clamped = NW'(1);
    end else if (cfg_num_i > NW'(NUM_STAGES)) begin
      num_clamped = NW'(NUM_STAGES);
    end else begin
      num_clamped = cfg_num_i;
    end
  end

  assign last_stage = ({1'b0, stage_o} == (num_q - NW'(1)));
  assign stage_inc  = stage_o + SW'(1);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d      = state_q;
    num_d        = num_q;
    stage_d      = stage_o;
    thr_d        = cnt_thr_o;
    stage_done_d = 1'b0;
    seq_done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          num_d   = num_clamped;
          stage_d = '0;
          thr_d   = table_q[0];
          state_d = CLEAR;
        end
      end

      CLEAR: begin
        state_d = abort_i ? IDLE : RUN;
      end

      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (cnt_tc_i) begin
          stage_done_d = 1'b1;
          if (!last_stage) begin
            stage_d = stage_inc;
            thr_d   = table_q[stage_inc];
            state_d = CLEAR;
          end else if (loop_en) begin
            stage_d = '0;
            thr_d   = table_q[0];
            state_d = CLEAR;
          end else begin
            // Final stage: leave the counter uncleared so its last value stays readable.
            seq_done_d = 1'b1;
            state_d    = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      num_q        <= NW'(1);
      stage_o      <= '0;
      cnt_thr_o    <= '0;
      cnt_en_o     <= 1'b0;
      cnt_clr_o    <= 1'b0;
      busy_o       <= 1'b0;
      stage_done_o <= 1'b0;
      seq_done_o   <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      stage_o      <= stage_d;
      cnt_thr_o    <= thr_d;
      cnt_en_o     <= (state_d == RUN);
      cnt_clr_o    <= (state_d == CLEAR);
      busy_o       <= (state_d != IDLE);
      stage_done_o <= stage_done_d;
      seq_done_o   <= seq_done_d;
    end
  end

  // The load above reads table_q before this write lands, so a same-edge write loads the old entry.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      // NOTE: the table is small control state with a defined reset value, so it is reset like any flop.
      for (int i = 0; i < NUM_STAGES; i++) begin
        table_q[i] <= '0;
      end
    end else if (cfg_we_i && (int'(cfg_idx_i) < NUM_STAGES)) begin
      table_q[cfg_idx_i] <= cfg_thr_i;
    end
  end

  a_en_clr_exclusive : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(cnt_en_o && cnt_clr_o));
  a_seq_done_with_stage_done : assert property (@(posedge clk_i) disable iff (!rst_ni)
    seq_done_o |-> stage_done_o);

endmodule

// File: doc/cnt_sequencer.md
# cnt_sequencer

Threshold-sequence controller for the hardware counter. It drives the counter's enable, clear and threshold inputs so that the counter steps through a programmable table of up to NUM_STAGES thresholds. Each stage runs to terminal count, then the counter is cleared and the next threshold is loaded. It sits between the counter control registers and the counter datapath and replaces direct software sequencing of enable and clear.

## Interface
- NUM_STAGES, 4, depth of the threshold table (≥2)
- CW, 32, threshold/counter width
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- start_i  in  1  start sequence (sampled only in IDLE)
- abort_i  in  1  abort sequence; wins over start_i
- loop_i  in  1  restart from stage 0 after last stage (sampled at each wrap)
- cfg_we_i  in  1  threshold table write strobe
- cfg_idx_i  in  $clog2(NUM_STAGES)  table write index
- cfg_thr_i  in  CW  table write data
- cfg_num_i  in  $clog2(NUM_STAGES)+1  active stage count, sampled on start
- cnt_tc_i  in  1  counter terminal count
- cnt_en_o  out  1  counter enable
- cnt_clr_o  out  1  counter clear
- cnt_thr_o  out  CW  counter threshold
- busy_o  out  1  sequence in progress
- stage_o  out  $clog2(NUM_STAGES)  current stage index
- stage_done_o  out  1  one-cycle pulse per completed stage
- seq_done_o  out  1  one-cycle pulse at sequence end

## Operation
- States: IDLE, CLEAR, RUN. All outputs are registered.
- Moore outputs: IDLE en=0 clr=0 busy=0; CLEAR en=0 clr=1 busy=1; RUN en=1 clr=0 busy=1.
- IDLE, start_i=1, abort_i=0: latch num = clamp(cfg_num_i, 1, NUM_STAGES). A value of 0 is treated as 1. Set stage=0, load cnt_thr_o ← table[0], go to CLEAR.
- CLEAR: always go to RUN next cycle.
- RUN, cnt_tc_i=0: stay in RUN.
- RUN, cnt_tc_i=1, stage<num-1: pulse stage_done_o, stage+1, cnt_thr_o ← table[stage+1], go to CLEAR.
- RUN, cnt_tc_i=1, stage=num-1, loop active: pulse stage_done_o, stage=0, cnt_thr_o ← table[0], go to CLEAR. seq_done_o is not pulsed.
- RUN, cnt_tc_i=1, stage=num-1, no loop: pulse stage_done_o and seq_done_o in the same cycle, go to IDLE. stage_o and cnt_thr_o hold their last values. The counter is not cleared, so its final value stays readable.
- abort_i=1 in CLEAR or RUN: go to IDLE next cycle. No done pulses. stage_o and cnt_thr_o hold. abort_i in IDLE has no effect.
- cnt_tc_i is ignored in IDLE and CLEAR.
- start_i is ignored while busy.
- Table writes are accepted in any state, including the cycle a stage is loaded. The table is read at the load edge, so the old entry is used on a same-cycle collision. Writes to not-yet-loaded stages affect the running sequence. cfg_num_i changes while busy are ignored.
- Reset: table entries=0, state IDLE, cnt_en_o=0, cnt_clr_o=0, cnt_thr_o=0, busy_o=0, stage_o=0, stage_done_o=0, seq_done_o=0.

## Timing
- start_i high at edge N: CLEAR during cycle N+1, RUN from cycle N+2.
- cnt_tc_i high at edge M (in RUN): stage_done_o high during cycle M+1, together with the CLEAR state or with IDLE.
- Stage length with a counter that counts each enabled cycle and asserts tc combinationally at val==thr: 1 CLEAR cycle + (thr+1) RUN cycles.
- Threshold 0 is legal: tc is seen in the first RUN cycle, giving a 2-cycle stage.
- Reset mid-sequence returns to the reset state at the next edge, with no pulses.

## Configuration
- Macro: CNT_SEQ_LOOP_EN.
- Defined: loop_i is honoured as described above.
- Undefined: loop_i is ignored and treated as 0. Every sequence ends in IDLE with seq_done_o after stage num-1.

## Test plan
Bench counter model: increments when en, cleared by clr, tc = (val==thr).
- Reset, then check idle outputs: all outputs 0, busy_o=0.
- Table {3,5,2,7}, cfg_num_i=4, start pulse:
  - stage_done_o pulses 5, 7, 4 and 9 cycles apart.
  - seq_done_o coincides with the 4th stage_done_o.
  - busy_o drops on the same cycle.
  - cnt_thr_o=7 and stage_o=3 afterwards.
- cfg_num_i=0 and cfg_num_i=7 with NUM_STAGES=4: 1 stage and 4 stages run, respectively.
- Table {2,2}, num=2, loop_i=1 (macro defined): stage_o sequence 0,1,0,1,… with no seq_done_o. Drop loop_i: sequence ends after the next stage 1. With the macro undefined, it ends after the first pass.
- Abort in RUN at stage 1 with start_i=1 in the same cycle: IDLE next cycle, no pulses, stage_o=1 held. A subsequent start restarts at stage 0.
- During stage 0, write table[1]=10: stage 1 lasts 11 RUN cycles. A write to table[1] on the stage 0→1 tc edge is not used; the old value is loaded.
